// File: rtl/hero_write_rx.sv
// hero_write_rx: hero write bus receiver.
// Frames beats into transactions, checks protocol, buffers into a stream FIFO.
module hero_write_rx #(
  parameter int DATA_WIDTH = 36,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BEATS  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       hero_cycle_type,
  input  logic [DATA_WIDTH-1:0]            hero_wdat,
  input  logic                             hero_clk_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic [CNT_WIDTH-1:0]             pkt_cnt,
  output logic [CNT_WIDTH-1:0]             drop_cnt,
  output logic                             err_overflow,
  output logic                             err_len,
  output logic                             err_proto,
  input  logic                             err_clr
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PKT,
    RX_DISCARD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] beat_cnt_nxt;

  logic is_valid;
  logic is_done;
  logic is_beat;
  logic is_rsvd;
  logic has_room;
  logic last_slot;

  logic push;
  logic push_sop;
  logic push_eop;
  logic pop;
  logic pkt_inc;
  logic drop_inc;
  logic set_ovf;
  logic set_len;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign is_valid = hero_clk_en && (hero_cycle_type == 4'd1);
  assign is_done  = hero_clk_en && (hero_cycle_type == 4'd2);
  assign is_beat  = is_valid || is_done;
  assign is_rsvd  = hero_clk_en && (hero_cycle_type > 4'd2);

  // Registered level only: a same-cycle pop is not credited.
  assign has_room  = fifo_level <= LW'(FIFO_DEPTH - MAX_BEATS);
  assign last_slot = beat_cnt == BW'(MAX_BEATS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RX_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RX_IDLE: begin
        if (is_valid)
          state_nxt = has_room ? RX_PKT : RX_DISCARD;
      end
      RX_PKT: begin
        if (is_done)
          state_nxt = RX_IDLE;
        else if (is_valid && last_slot)
          state_nxt = RX_DISCARD;
      end
      RX_DISCARD: begin
        if (is_done)
          state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    push         = 1'b0;
    push_sop     = 1'b0;
    push_eop     = 1'b0;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    set_ovf      = 1'b0;
    set_len      = 1'b0;
    beat_cnt_nxt = beat_cnt;
    unique case (state)
      RX_IDLE: begin
        if (is_beat && has_room) begin
          push         = 1'b1;
          push_sop     = 1'b1;
          push_eop     = is_done;
          pkt_inc      = is_done;
          beat_cnt_nxt = BW'(1);
        end else if (is_beat) begin
          drop_inc = 1'b1;
          set_ovf  = 1'b1;
        end
      end
      RX_PKT: begin
        if (is_beat) begin
          push         = 1'b1;
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (is_done) begin
            push_eop = 1'b1;
            pkt_inc  = 1'b1;
          end else if (last_slot) begin
            push_eop = 1'b1;
            pkt_inc  = 1'b1;
            set_len  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {push_sop, push_eop, hero_wdat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)
        fifo_level <= fifo_level + 1'b1;
      else if (pop && !push)
        fifo_level <= fifo_level - 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = fifo_level != '0;
  assign out_sop   = out_valid && head[EW-1];
  assign out_eop   = out_valid && head[EW-2];
  assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt      <= '0;
      drop_cnt     <= '0;
      err_overflow <= 1'b0;
      err_len      <= 1'b0;
      err_proto    <= 1'b0;
    end else begin
      if (pkt_inc)
        pkt_cnt <= pkt_cnt + 1'b1;
      if (drop_inc)
        drop_cnt <= drop_cnt + 1'b1;
      err_overflow <= set_ovf || (err_overflow && !err_clr);
      err_len      <= set_len || (err_len && !err_clr);
      err_proto    <= is_rsvd || (err_proto && !err_clr);
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst)
      !(push && fifo_level == LW'(FIFO_DEPTH))
  );

endmodule

// File: doc/hero_write_rx.md
Name: hero_write_rx

Overview:
- Receive end of the hero write bus: cycle_type, wdat and clk_en per cycle, with no backpressure on the bus.
- Frames beats into transactions, checks the protocol, buffers accepted beats in a FIFO, and presents them downstream on a valid/ready stream with sop/eop markers.
- Sits between the hero bus and the bag-side write consumer. Reports drops, length violations and bad encodings through sticky flags and counters.

Parameters:
- DATA_WIDTH, 36, width of wdat (equals HERO_WIDTH).
- FIFO_DEPTH, 16, beat buffer entries; must be >= MAX_BEATS.
- MAX_BEATS, 8, maximum beats per transaction, counting the DONE beat.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- hero_cycle_type  in  4  0=IDLE, 1=VALID, 2=DONE, 3..15 reserved
- hero_wdat  in  DATA_WIDTH  beat data
- hero_clk_en  in  1  beat qualifier; 0 means the cycle is ignored entirely
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  head data
- out_sop  out  1  head is the first beat of its transaction
- out_eop  out  1  head is the last beat of its transaction
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries
- pkt_cnt  out  CNT_WIDTH  transactions fully pushed (eop written); wraps
- drop_cnt  out  CNT_WIDTH  transactions rejected at admission; wraps
- err_overflow  out  1  sticky: an admission was rejected
- err_len  out  1  sticky: a transaction exceeded MAX_BEATS
- err_proto  out  1  sticky: a reserved cycle_type was seen with clk_en=1
- err_clr  in  1  clears all three sticky flags

Behaviour:
- Reset: all outputs 0, FIFO empty, state RX_IDLE, beat counter 0.
- A beat exists only when hero_clk_en=1 and cycle_type is VALID or DONE.
- IDLE cycles, and any cycle with clk_en=0, change nothing in any state.
- Reserved cycle_type with clk_en=1: set err_proto, ignore the beat, keep the current state.
- Admission (RX_IDLE, beat arrives):
  - free = FIFO_DEPTH - fifo_level, using the registered level; a pop in the same cycle is not credited.
  - free >= MAX_BEATS: push with sop=1, set beat count to 1.
  - VALID goes to RX_PKT. DONE pushes sop=1, eop=1, stays in RX_IDLE and increments pkt_cnt.
  - free < MAX_BEATS: drop the beat, set err_overflow, increment drop_cnt. VALID goes to RX_DISCARD; DONE stays in RX_IDLE.
- RX_PKT:
  - VALID pushes sop=0, eop=0 and increments the beat count.
  - DONE pushes eop=1, increments pkt_cnt and goes to RX_IDLE.
  - If the beat being pushed is beat number MAX_BEATS and it is VALID: force eop=1, set err_len, increment pkt_cnt, go to RX_DISCARD.
- RX_DISCARD: drop VALID beats. Drop the DONE beat as well, then go to RX_IDLE.
- FIFO:
  - A push in cycle N appears at the head with out_valid=1 in cycle N+1; no combinational bypass.
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle leave the level unchanged.
  - out_data, out_sop and out_eop hold stable while out_valid=1 and out_ready=0.
  - Admission guarantees no push ever occurs while full. Implementation carries an assertion for this.
- Pointers wrap modulo FIFO_DEPTH; FIFO_DEPTH need not be a power of two.
- Counters wrap from 2^CNT_WIDTH-1 to 0.
- If err_clr coincides with a new error event, the set wins.
- Reset mid-transaction flushes the FIFO, returns to RX_IDLE and clears all counters and flags. No partial packet survives.

Test Plan:
- After reset, out_ready=1, send VALID(0xA), VALID(0xB), DONE(0xC) -> outputs 0xA sop=1, 0xB, then 0xC eop=1 on cycles 2,3,4; pkt_cnt=1; no flags set.
- A single DONE(0x5) with IDLE and clk_en=0 cycles interleaved mid-packet -> one beat with sop=eop=1; gap cycles push nothing.
- out_ready=0, send two 8-beat packets (level 16) -> third packet's VALID is dropped through its DONE; err_overflow=1, drop_cnt=1, level stays 16; draining yields exactly 16 beats.
- A 10-beat packet (9 VALID + DONE) -> 8 beats pushed with eop on beat 8; err_len=1; beats 9-10 discarded; state returns to RX_IDLE; the next packet is accepted.
- cycle_type=7 with clk_en=1 inside a packet -> err_proto=1 and the packet is otherwise intact. Then err_clr=1 in the same cycle as cycle_type=9 -> err_proto stays 1.
- Assert rst while 3 beats are buffered mid-packet -> next cycle out_valid=0, level 0, all counters 0; a following packet is received normally.
